// File: rtl/spi_pkg.sv
// Shared definitions for the SPI target.
//   spi_state_t   : framing state (IDLE between frames, ACTIVE while selected)
//   SPI_MODE0..3  : {CPOL, CPHA} pairs for the four SPI clock modes
package spi_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } spi_state_t;

   localparam logic [1:0] SPI_MODE0 = 2'b00;
   localparam logic [1:0] SPI_MODE1 = 2'b01;
   localparam logic [1:0] SPI_MODE2 = 2'b10;
   localparam logic [1:0] SPI_MODE3 = 2'b11;

endpackage

// File: rtl/spi_target_if.sv
// Bundle of the SPI pins and the system-side word interface of spi_target.
//   spi_clk, cs_n, mosi : asynchronous pins from the SPI master
//   miso                : serial data back to the master, 0 while deselected
//   tx_data             : word to transmit, sampled only when tx_load pulses
//   tx_load             : 1-cycle pulse, tx_data was captured this cycle
//   rx_data             : last complete received word, held between words
//   rx_valid            : 1-cycle pulse, rx_data has just been updated
//   frame_start         : 1-cycle pulse on a detected chip-select fall
//   busy                : high while a frame is in progress
// Handshake: there is no backpressure. rx_valid, tx_load and frame_start are
// single-cycle strobes; system logic must consume rx_data or provide tx_data
// in the cycle(s) around the strobe. tx_data must be stable whenever tx_load
// may fire (frame start or word completion).
interface spi_target_if #(parameter int WIDTH = 8);

   logic             spi_clk;
   logic             cs_n;
   logic             mosi;
   logic             miso;
   logic [WIDTH-1:0] tx_data;
   logic             tx_load;
   logic [WIDTH-1:0] rx_data;
   logic             rx_valid;
   logic             frame_start;
   logic             busy;

   modport slave (
      input  spi_clk, cs_n, mosi, tx_data,
      output miso, tx_load, rx_data, rx_valid, frame_start, busy
   );

   modport master (
      output spi_clk, cs_n, mosi, tx_data,
      input  miso, tx_load, rx_data, rx_valid, frame_start, busy
   );

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin with rise/fall detection.
//   clk, rst  : system clock, synchronous active-high reset
//   din       : asynchronous input pin
//   rise/fall : 1-cycle pulses when the synchronised level changes
// All flops reset to RESET_VAL (the pin's idle level) so that releasing reset
// with the pin idle produces no edge.
module spi_sync_edge #(
   parameter int   STAGES    = 2,
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync_q;
   logic              prev_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= {STAGES{RESET_VAL}};
         prev_q <= RESET_VAL;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], din};
         prev_q <= sync_q[STAGES-1];
      end
   end

   assign rise = sync_q[STAGES-1] & ~prev_q;
   assign fall = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_target.sv
// SPI target with configurable word width, clock mode and bit order.
//   clk, rst  : system clock, synchronous active-high reset
//   bus       : spi_target_if.slave (SPI pins plus word-level strobes)
//   state_dbg : current framing state
// Pins are oversampled in the clk domain; every pin event takes effect
// SYNC_STAGES+1 cycles after it happens.
module spi_target
   import spi_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter bit CPOL        = 1'b0,
   parameter bit CPHA        = 1'b0,
   parameter bit LSB_FIRST   = 1'b0,
   parameter int SYNC_STAGES = 2
) (
   input  logic          clk,
   input  logic          rst,
   spi_target_if.slave   bus,
   output spi_state_t    state_dbg
);

   localparam int CNT_W    = $clog2(WIDTH);
   localparam int SETTLE_W = $clog2(SYNC_STAGES + 2);

   logic sclk_rise, sclk_fall, cs_rise, cs_fall;
   logic [SYNC_STAGES-1:0] mosi_sync_q;
   logic mosi_s;

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(CPOL)) u_sclk_sync (
      .clk(clk), .rst(rst), .din(bus.spi_clk), .rise(sclk_rise), .fall(sclk_fall)
   );

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
      .clk(clk), .rst(rst), .din(bus.cs_n), .rise(cs_rise), .fall(cs_fall)
   );

   // Same depth as the clock synchroniser, so the mosi sample seen together
   // with a detected clock edge is the pin value at that edge.
   always_ff @(posedge clk) begin
      if (rst) mosi_sync_q <= '0;
      else     mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
   end
   assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

   logic lead_edge, trail_edge, sample_edge, shift_edge;
   assign lead_edge   = CPOL ? sclk_fall : sclk_rise;
   assign trail_edge  = CPOL ? sclk_rise : sclk_fall;
   assign sample_edge = CPHA ? trail_edge : lead_edge;
   assign shift_edge  = CPHA ? lead_edge  : trail_edge;

   spi_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] rx_q, tx_q, rx_data_q;
   logic             rx_valid_q, tx_load_q, frame_start_q;
   logic             skip_q;
   logic [SETTLE_W-1:0] settle_q;
   logic             armed;

   // If reset is released while cs_n is still low, the cs synchroniser
   // flushes from its idle value and reports a fall within SYNC_STAGES
   // cycles. Frame starts are ignored until that window has passed, so an
   // interrupted frame is dropped until cs_n rises and falls again.
   assign armed = (settle_q == SETTLE_W'(SYNC_STAGES + 1));

   logic start, word_done, reload, stop;
   logic [WIDTH-1:0] rx_next, tx_next;

   assign rx_next = LSB_FIRST ? {mosi_s, rx_q[WIDTH-1:1]} : {rx_q[WIDTH-2:0], mosi_s};
   assign tx_next = LSB_FIRST ? {1'b0, tx_q[WIDTH-1:1]}   : {tx_q[WIDTH-2:0], 1'b0};

   always_comb begin
      state_d   = state_q;
      start     = 1'b0;
      word_done = 1'b0;
      reload    = 1'b0;
      stop      = 1'b0;
      case (state_q)
         IDLE: begin
            if (cs_fall && armed) begin
               state_d = ACTIVE;
               start   = 1'b1;
            end
         end
         ACTIVE: begin
            word_done = sample_edge && (cnt_q == CNT_W'(WIDTH - 1));
            if (cs_rise) begin
               state_d = IDLE;
               stop    = 1'b1;
            end
            // A word that completes as the frame closes is delivered, but no
            // new transmit word is fetched.
            reload = word_done && !cs_rise;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         rx_q          <= '0;
         tx_q          <= '0;
         rx_data_q     <= '0;
         rx_valid_q    <= 1'b0;
         tx_load_q     <= 1'b0;
         frame_start_q <= 1'b0;
         skip_q        <= 1'b0;
         settle_q      <= '0;
      end else begin
         state_q       <= state_d;
         rx_valid_q    <= 1'b0;
         tx_load_q     <= 1'b0;
         frame_start_q <= 1'b0;
         if (!armed) settle_q <= settle_q + 1'b1;

         // skip_q holds the freshly loaded first bit through one shift edge:
         // for CPHA=1 that is the leading edge of every word; for CPHA=0 it
         // is the trailing edge right after a back-to-back reload.
         if (start) begin
            tx_q          <= bus.tx_data;
            tx_load_q     <= 1'b1;
            frame_start_q <= 1'b1;
            cnt_q         <= '0;
            skip_q        <= CPHA;
         end

         if (state_q == ACTIVE) begin
            if (sample_edge) begin
               rx_q  <= rx_next;
               cnt_q <= word_done ? '0 : cnt_q + 1'b1;
            end
            if (word_done) begin
               rx_data_q  <= rx_next;
               rx_valid_q <= 1'b1;
            end
            if (reload) begin
               tx_q      <= bus.tx_data;
               tx_load_q <= 1'b1;
               skip_q    <= 1'b1;
            end else if (shift_edge) begin
               if (skip_q) skip_q <= 1'b0;
               else        tx_q   <= tx_next;
            end
            if (stop) begin
               cnt_q <= '0;
               rx_q  <= '0;
            end
         end
      end
   end

   assign bus.miso        = (state_q == ACTIVE) ? (LSB_FIRST ? tx_q[0] : tx_q[WIDTH-1]) : 1'b0;
   assign bus.busy        = (state_q == ACTIVE);
   assign bus.rx_data     = rx_data_q;
   assign bus.rx_valid    = rx_valid_q;
   assign bus.tx_load     = tx_load_q;
   assign bus.frame_start = frame_start_q;
   assign state_dbg       = state_q;

endmodule
